gray_binary_seq: RTL and testbench

GRAY_BINARY_SEQ -- requirements
Module: gray_binary_seq

---
 rtl/gray_binary_seq.sv | 103 ++++++++++
 tb/tb_gray_binary_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/gray_binary_seq.sv
// Sequential Gray-to-binary decoder: resolves one bit per clock, MSB first, and
// flags consecutive accepted codes that are not exactly one bit apart.
module gray_binary_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] g_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] b_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             step_err
);

    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, DECODE, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] g_cur;
    logic [WIDTH-1:0] b_work;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] g_prev;
    logic             prev_valid;
    logic             err_pend;

    logic [IW-1:0]    idx_p1;
    logic [WIDTH-1:0] b_next;
    logic [WIDTH-1:0] diff;
    logic             one_bit;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        idx_p1      = idx + IW'(1);
        b_next      = b_work;
        b_next[idx] = b_work[idx_p1] ^ g_cur[idx];
        diff        = g_in ^ g_prev;
        // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
        one_bit     = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            g_cur      <= '0;
            b_work     <= '0;
            idx        <= '0;
            g_prev     <= '0;
            prev_valid <= 1'b0;
            err_pend   <= 1'b0;
            b_out      <= '0;
            out_valid  <= 1'b0;
            step_err   <= 1'b0;
            busy       <= 1'b0;
            in_ready   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        g_cur      <= g_in;
                        b_work     <= {g_in[WIDTH-1], {(WIDTH-1){1'b0}}};
                        idx        <= IW'(WIDTH - 2);
                        g_prev     <= g_in;
                        prev_valid <= 1'b1;
                        // The step verdict uses the previous word, so it is settled here.
                        err_pend   <= prev_valid && !one_bit;
                        state      <= DECODE;
                        in_ready   <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                DECODE: begin
                    b_work <= b_next;
                    idx    <= idx - IW'(1);
                    if (idx == '0) begin
                        state     <= DONE;
                        b_out     <= b_next;
                        out_valid <= 1'b1;
                        step_err  <= err_pend;
                    end
                end
                DONE: begin
                    // Return to IDLE with in_ready already low for this edge: one bubble cycle.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_binary_seq.sv
// Self-checking bench for gray_binary_seq (WIDTH=8): directed vector table,
// reset corner cases, and randomized words against an arithmetic reference model.
module tb_gray_binary_seq;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] g_in;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] b_out;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             step_err;

    int checks = 0;
    int errors = 0;

    // Reference model state: last accepted code since reset.
    logic [WIDTH-1:0] m_prev = '0;
    logic             m_prev_valid = 1'b0;

    typedef struct {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] b;
        logic             err;
        int               stall;
    } vec_t;

    vec_t tbl[6];

    gray_binary_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .g_in      (g_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .b_out     (b_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .step_err  (step_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Binary value is the XOR of all right-shifts of the Gray code.
    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b = '0;
        for (int k = 0; k < WIDTH; k++) b ^= (g >> k);
        return b;
    endfunction

    task automatic model_step(input logic [WIDTH-1:0] g, output logic [WIDTH-1:0] b,
                              output logic err);
        b = gray_to_bin(g);
        err = m_prev_valid && ($countones(g ^ m_prev) != 1);
        m_prev = g;
        m_prev_valid = 1'b1;
    endtask

    task automatic model_reset();
        m_prev = '0;
        m_prev_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check({tag, " in_ready timeout"}, 32'(in_ready), 32'd1);
    endtask

    // One complete transaction with optional backpressure in DONE.
    task automatic do_word(input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] exp_b,
                           input logic exp_err, input int stall, input string tag);
        int lat;
        wait_ready(tag);
        in_valid = 1'b1;
        g_in = g;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        g_in = WIDTH'($urandom);
        check({tag, " busy after accept"}, 32'(busy), 32'd1);
        check({tag, " in_ready after accept"}, 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(WIDTH - 1));
        check({tag, " b_out"}, 32'(b_out), 32'(exp_b));
        check({tag, " step_err"}, 32'(step_err), 32'(exp_err));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            g_in = WIDTH'($urandom);
            @(posedge clk);
            #1;
            check({tag, " stall b_out"}, 32'(b_out), 32'(exp_b));
            check({tag, " stall step_err"}, 32'(step_err), 32'(exp_err));
            check({tag, " stall out_valid"}, 32'(out_valid), 32'd1);
            check({tag, " stall in_ready"}, 32'(in_ready), 32'd0);
        end
        // in_valid stays high across the output handshake: it must not be captured.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        g_in = WIDTH'($urandom);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        check({tag, " out_valid after release"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready after release"}, 32'(in_ready), 32'd1);
        check({tag, " busy after release"}, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " b_out"}, 32'(b_out), 32'd0);
        check({tag, " out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " step_err"}, 32'(step_err), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " in_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] eb;
        logic             ee;
        logic [WIDTH-1:0] g;
        int               seen;

        tbl[0] = '{g: 8'h80, b: 8'hFF, err: 1'b0, stall: 0};
        tbl[1] = '{g: 8'h81, b: 8'hFE, err: 1'b0, stall: 5};
        tbl[2] = '{g: 8'h87, b: 8'hFA, err: 1'b1, stall: 1};
        tbl[3] = '{g: 8'h87, b: 8'hFA, err: 1'b1, stall: 0};
        tbl[4] = '{g: 8'h80, b: 8'hFF, err: 1'b1, stall: 2};
        tbl[5] = '{g: 8'h00, b: 8'h00, err: 1'b0, stall: 0};

        rst_n = 1'b1;
        in_valid = 1'b0;
        g_in = '0;
        out_ready = 1'b0;

        // Reset asserted between edges must clear outputs immediately.
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1 check("in_ready held in reset", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready after reset", 32'(in_ready), 32'd1);
        check("busy after reset", 32'(busy), 32'd0);

        foreach (tbl[i]) begin
            model_step(tbl[i].g, eb, ee);
            do_word(tbl[i].g, tbl[i].b, tbl[i].err, tbl[i].stall, $sformatf("vec%0d", i));
        end

        // Reset while DONE holds a result.
        wait_ready("done_rst");
        in_valid = 1'b1;
        g_in = 8'h12;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (WIDTH - 1) @(posedge clk);
        #1 check("done_rst out_valid before", 32'(out_valid), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("done_rst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1 check("done_rst in_ready", 32'(in_ready), 32'd1);

        // Reset pulse on the third DECODE cycle discards the word.
        wait_ready("dec_rst");
        in_valid = 1'b1;
        g_in = 8'h55;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("dec_rst busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1 if (out_valid) seen++;
        end
        check("dec_rst no out_valid", 32'(seen), 32'd0);
        check("dec_rst idle", 32'(busy), 32'd0);
        check("dec_rst in_ready", 32'(in_ready), 32'd1);
        model_step(8'hFF, eb, ee);
        do_word(8'hFF, 8'hAA, 1'b0, 0, "after_dec_rst");

        // Randomized words: half are single-bit steps, half arbitrary codes.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 0) g = m_prev ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
            else g = WIDTH'($urandom);
            model_step(g, eb, ee);
            do_word(g, eb, ee, int'($urandom_range(0, 3)), $sformatf("rnd%0d g=%0h", n, g));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
